// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with runtime pattern load and saturating match counter
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_i         serial data bit, sampled when in_valid_i is high
//   in_valid_i   qualifies in_i
//   overlap_i    1 = overlapping detection, 0 = restart priming after a match
//   pat_load_i   load pat_in_i and restart priming (beats in_valid_i)
//   pat_in_i     new pattern, MSB is the first-received bit
//   clr_cnt_i    synchronous clear of match_cnt_o
//   out_o        Mealy match in the cycle that completes the pattern
//   out_q_o      out_o registered
//   match_cnt_o  saturating match count
module seq_detect_param #(
  parameter int LEN = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(4'b1101),
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_i,
  input  logic             in_valid_i,
  input  logic             overlap_i,
  input  logic             pat_load_i,
  input  logic [LEN-1:0]   pat_in_i,
  input  logic             clr_cnt_i,
  output logic             out_o,
  output logic             out_q_o,
  output logic [CNT_W-1:0] match_cnt_o
);
  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);
  localparam logic [FW-1:0] ARM = FW'(LEN - 1);
  logic [LEN-1:0] pat_q, pat_d, hist_q, hist_d, cand;
  logic [FW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      out_q  <= out_o;
    end
  // fill is the FSM state: FILL_0..FILL_LEN-1 while priming, ARMED at LEN
  always_comb begin
    pat_d  = pat_load_i ? pat_in_i : pat_q;
    hist_d = pat_load_i ? '0 : in_valid_i ? cand : hist_q;
    fill_d = fill_q;
    if (pat_load_i) fill_d = '0;
    else if (in_valid_i) fill_d = (out_o && !overlap_i) ? '0 : (fill_q == FULL) ? FULL : fill_q + FW'(1);
    cnt_d = clr_cnt_i ? CNT_W'(out_o) : (out_o && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // the newest bit joins the history combinationally so the match is Mealy
  always_comb begin
    cand        = {hist_q[LEN-2:0], in_i};
    out_o       = rst_ni & in_valid_i & ~pat_load_i & (fill_q >= ARM) & (cand == pat_q);
    out_q_o     = out_q;
    match_cnt_o = cnt_q;
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed self-checking bench for seq_detect_param
module tb_seq_detect_param;
  logic clk = 0, rst_n = 0, in = 0, in_valid = 0, overlap = 1, pat_load = 0, clr_cnt = 0;
  logic [3:0] pat_in = '0;
  logic out_a, oq_a, out_b, oq_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic pe = 0;
  int cmp = 0, err = 0;
  always #5 clk = ~clk;
  seq_detect_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in), .in_valid_i(in_valid), .overlap_i(overlap),
    .pat_load_i(pat_load), .pat_in_i(pat_in), .clr_cnt_i(clr_cnt),
    .out_o(out_a), .out_q_o(oq_a), .match_cnt_o(cnt_a));
  seq_detect_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in), .in_valid_i(in_valid), .overlap_i(overlap),
    .pat_load_i(pat_load), .pat_in_i(pat_in), .clr_cnt_i(clr_cnt),
    .out_o(out_b), .out_q_o(oq_b), .match_cnt_o(cnt_b));
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic b, input logic e, input string tag);
    in = b; in_valid = 1;
    #2 chk(32'(out_a), 32'(e), tag);
    @(posedge clk); #1;
    chk(32'(oq_a), 32'(e), {tag, "_q"});
    in_valid = 0;
  endtask
  task automatic stream(input logic [31:0] bits, input logic [31:0] exp, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in = 1; in_valid = 0;
      #2 chk(32'(out_a), 0, "gap_out");
      @(posedge clk); #1;
    end
  endtask
  task automatic ld(input logic [3:0] p);
    pat_load = 1; pat_in = p; in = 1; in_valid = 1;
    #2 chk(32'(out_a), 0, "load_out");
    @(posedge clk); #1;
    pat_load = 0; in_valid = 0;
  endtask
  task automatic idle_clr;
    clr_cnt = 1; in_valid = 0;
    @(posedge clk); #1;
    clr_cnt = 0;
  endtask
  initial begin
    in_valid = 1; in = 1;
    #2 chk(32'(out_a), 0, "rst_out");
    @(posedge clk); #1;
    chk(32'(oq_a), 0, "rst_out_q");
    chk(32'(cnt_a), 0, "rst_cnt");
    rst_n = 1; in_valid = 0;
    overlap = 1;
    stream(32'b1101101, 32'b0001001, 7, "ovl");
    chk(32'(cnt_a), 2, "ovl_cnt");
    idle_clr;
    chk(32'(cnt_a), 0, "clr_nomatch");
    overlap = 0;
    ld(4'b1101);
    stream(32'b1101101, 32'b0001000, 7, "novl1");
    clr_cnt = 1; ld(4'b1101); clr_cnt = 0;
    stream(32'b11011101, 32'b00010001, 8, "novl2");
    chk(32'(cnt_a), 2, "novl_cnt");
    overlap = 1;
    ld(4'b1101);
    stream(32'b11101, 32'b00001, 5, "self");
    ld(4'b1101);
    send(1, 0, "gap_b1"); gap(1);
    send(1, 0, "gap_b2"); gap(2);
    send(1, 0, "gap_b3"); gap(3);
    send(0, 0, "gap_b4"); gap(1);
    send(1, 1, "gap_b5"); gap(2);
    stream(32'b110, 32'b000, 3, "pre");
    ld(4'b0110);
    stream(32'b0110110, 32'b0001001, 7, "newpat");
    idle_clr;
    ld(4'b1101);
    stream(32'b1101101101101101101, 32'b0001001001001001001, 19, "sat");
    chk(32'(cnt_a), 6, "sat_cnt8");
    chk(32'(cnt_b), 3, "sat_cnt2");
    send(1, 0, "clrm_b1"); send(0, 0, "clrm_b2");
    clr_cnt = 1; send(1, 1, "clrm_b3"); clr_cnt = 0;
    chk(32'(cnt_a), 1, "clr_match_cnt8");
    chk(32'(cnt_b), 1, "clr_match_cnt2");
    idle_clr;
    chk(32'(cnt_b), 0, "clr_nomatch2");
    stream(32'b1101, 32'b0001, 4, "arst_pre");
    chk(32'(oq_a), 1, "arst_pre_q");
    #2 rst_n = 0; in = 1; in_valid = 1;
    #1 chk(32'(oq_a), 0, "arst_out_q");
    chk(32'(cnt_a), 0, "arst_cnt");
    chk(32'(dut.fill_q), 0, "arst_fill");
    chk(32'(out_a), 0, "arst_out");
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    ld(4'b1101);
    stream(32'b110, 32'b000, 3, "arst2_pre");
    #2 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    send(1, 0, "arst_after");
    stream(32'b1101, 32'b0001, 4, "arst_fresh");
    chk(32'(cnt_a), 1, "arst_fresh_cnt");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
